timer_multi: RTL and testbench
==============================

TIMER_MULTI -- requirements
Module: timer_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, giving the number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, giving the counter and compare width (8..32).
REQ-003 SHALL have parameter PRESC_W, default 16, giving the prescaler width (1..32).
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_en_i  input  1  register write strobe.
REQ-007 SHALL have port wr_addr_i  input  32  write byte address.
REQ-008 SHALL have port wr_data_i  input  32  write data.
REQ-009 SHALL have port rd_addr_i  input  32  read byte address.
REQ-010 SHALL have port rd_data_o  output  32  registered read data.
REQ-011 SHALL have port timer_int_vec_o  output  NUM_CH  per-channel interrupt (pending AND int-enable).
REQ-012 SHALL have port timer_int_flag_o  output  1  OR-reduction of timer_int_vec_o.

Function
REQ-013 SHALL decode the channel from addr[6:4] and the register from addr[3:0] as CTRL 0x0, COUNT 0x4, EVALUE 0x8, PRESC 0xC.
REQ-014 SHALL ignore writes to channels >= NUM_CH, to unmapped offsets and to COUNT, which is read-only.
REQ-015 SHALL read unmapped locations as zero and zero-extend narrower fields to 32 bits; writes truncate to field width.
REQ-016 SHALL update rd_data_o one cycle after rd_addr_i, returning register contents before that edge's updates.
REQ-017 SHALL define the CTRL bits as: [0] enable, [1] int enable, [2] pending, [3] mode (0 one-shot, 1 periodic); bits [31:4] read zero.
REQ-018 SHALL make a CTRL write update bits 0, 1 and 3 directly; on bit 2, writing 0 clears pending and writing 1 has no effect.
REQ-019 SHALL hold COUNT and the prescale counter at 0 while enable=0.
REQ-020 SHALL, while enabled, increment the prescale counter each cycle and generate a tick then reset it to 0 when it equals PRESC; PRESC=0 gives a tick every cycle.
REQ-021 SHALL, on a tick, expire the channel if COUNT >= EVALUE, otherwise increment COUNT by 1.
REQ-022 SHALL, on expiry, set pending=1 and COUNT=0; in one-shot mode also clear enable; in periodic mode keep running.
REQ-023 SHALL expire EVALUE=0 on the first tick after enable.
REQ-024 SHALL apply an EVALUE write from the next cycle; if COUNT is already >= the new value, the next tick expires.
REQ-025 SHALL let hardware expiry win over a same-cycle software write: pending ends at 1, and enable ends at 0 in one-shot mode.
REQ-026 SHALL leave channels independent; simultaneous expiries on several channels each set their own pending bit.
REQ-027 SHALL drive timer_int_vec_o and timer_int_flag_o combinationally from the registered CTRL bits.
REQ-028 SHALL not require wrap-around handling for COUNT, since expiry occurs at EVALUE <= 2^CNT_W-1.

Reset
REQ-029 SHALL clear all CTRL, COUNT, EVALUE, PRESC and prescale counters, rd_data_o and both interrupt outputs to 0 on rst_n low.
REQ-030 SHALL, on reset asserted mid-count, abort all channels immediately, and after release no channel SHALL run until software sets enable.

Structure
REQ-031 SHALL place the register offsets, CTRL bit indices and channel stride in the shared defines header.
REQ-032 SHALL implement one channel (prescaler, counter, CTRL/EVALUE/PRESC registers) as sub-module timer_chan, instantiated NUM_CH times by generate; the top handles address decode and the read mux.

Verification
REQ-033 SHALL check one-shot expiry: ch0 EVALUE=5, PRESC=0, CTRL=0x3 -> pending set on the 6th tick, enable=0, timer_int_flag_o=1, COUNT=0.
REQ-034 SHALL check periodic mode with prescaler: ch1 EVALUE=3, PRESC=2, CTRL=0xB -> pending every 12 cycles; clearing pending between expiries re-raises it at the next expiry.
REQ-035 SHALL check pending clear: write CTRL bit2=1 while pending=0 -> pending stays 0; write 0 after expiry -> pending=0 and interrupt deasserts the next cycle.
REQ-036 SHALL check simultaneous events: a pending-clear write in the expiry cycle -> pending=1; ch0 and ch2 expiring in the same cycle -> timer_int_vec_o=4'b0101.
REQ-037 SHALL check address rules: write to COUNT or channel 5 with NUM_CH=4 -> no state change; read of 0x50 -> 0; read of COUNT returns its value one cycle later.
REQ-038 SHALL check reset: rst_n low mid-count -> all registers and outputs 0; after release COUNT stays 0 with enable=0.

Source files
------------

// File: rtl/timer_multi_pkg.sv
// Shared register map, CTRL layout and address-decode constants for timer_multi.
package timer_multi_pkg;

    localparam int unsigned CH_STRIDE = 16;
    localparam int unsigned CH_LSB    = $clog2(CH_STRIDE);
    localparam int unsigned CH_MSB    = CH_LSB + 2;
    localparam int unsigned OFF_MSB   = CH_LSB - 1;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_COUNT  = 4'h4;
    localparam logic [3:0] REG_EVALUE = 4'h8;
    localparam logic [3:0] REG_PRESC  = 4'hC;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_IE   = 1;
    localparam int unsigned CTRL_PEND = 2;
    localparam int unsigned CTRL_MODE = 3;

    // Field order mirrors the CTRL bit indices above (mode is bit 3, en is bit 0).
    typedef struct packed {
        logic mode;
        logic pend;
        logic ie;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/timer_chan.sv
// One timer channel: prescaler, up-counter with compare, and its CTRL/EVALUE/PRESC registers.
module timer_chan
    import timer_multi_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ctrl_we_i,
    input  logic               evalue_we_i,
    input  logic               presc_we_i,
    input  logic [31:0]        wr_data_i,
    output ctrl_t              ctrl_o,
    output logic [CNT_W-1:0]   count_o,
    output logic [CNT_W-1:0]   evalue_o,
    output logic [PRESC_W-1:0] presc_o
);

    ctrl_t               ctrl_q, ctrl_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    evalue_q, evalue_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [PRESC_W-1:0]  psc_q, psc_d;
    logic                tick;
    logic                expire;

    assign tick   = ctrl_q.en && (psc_q == presc_q);
    assign expire = tick && (cnt_q >= evalue_q);

    always_comb begin
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;
        evalue_d = evalue_q;
        presc_d  = presc_q;
        psc_d    = psc_q;

        if (ctrl_q.en) begin
            psc_d = tick ? '0 : psc_q + PRESC_W'(1);
            if (expire) begin
                cnt_d = '0;
            end else if (tick) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (ctrl_we_i) begin
            ctrl_d.en   = wr_data_i[CTRL_EN];
            ctrl_d.ie   = wr_data_i[CTRL_IE];
            ctrl_d.mode = wr_data_i[CTRL_MODE];
            if (!wr_data_i[CTRL_PEND]) begin
                ctrl_d.pend = 1'b0;
            end
        end

        // Hardware expiry overrides a software CTRL write in the same cycle.
        if (expire) begin
            ctrl_d.pend = 1'b1;
            if (!ctrl_q.mode) begin
                ctrl_d.en = 1'b0;
            end
        end

        if (!ctrl_d.en) begin
            cnt_d = '0;
            psc_d = '0;
        end

        if (evalue_we_i) begin
            evalue_d = wr_data_i[CNT_W-1:0];
        end
        if (presc_we_i) begin
            presc_d = wr_data_i[PRESC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            cnt_q    <= '0;
            evalue_q <= '0;
            presc_q  <= '0;
            psc_q    <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            evalue_q <= evalue_d;
            presc_q  <= presc_d;
            psc_q    <= psc_d;
        end
    end

    assign ctrl_o   = ctrl_q;
    assign count_o  = cnt_q;
    assign evalue_o = evalue_q;
    assign presc_o  = presc_q;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel timer: register address decode, NUM_CH timer_chan instances, registered read mux.
module timer_multi
    import timer_multi_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PRESC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [31:0]       wr_addr_i,
    input  logic [31:0]       wr_data_i,
    input  logic [31:0]       rd_addr_i,
    output logic [31:0]       rd_data_o,
    output logic [NUM_CH-1:0] timer_int_vec_o,
    output logic              timer_int_flag_o
);

    logic [2:0]        wr_ch, rd_ch;
    logic [OFF_MSB:0]  wr_off, rd_off;
    logic              wr_hi_ok, rd_hi_ok;
    logic [31:0]       rd_data_q, rd_data_d;

    ctrl_t              ctrl_w   [NUM_CH];
    logic [CNT_W-1:0]   count_w  [NUM_CH];
    logic [CNT_W-1:0]   evalue_w [NUM_CH];
    logic [PRESC_W-1:0] presc_w  [NUM_CH];

    // Addresses above the channel field alias nothing and are treated as unmapped.
    assign wr_ch    = wr_addr_i[CH_MSB:CH_LSB];
    assign wr_off   = wr_addr_i[OFF_MSB:0];
    assign wr_hi_ok = (wr_addr_i[31:CH_MSB+1] == '0);
    assign rd_ch    = rd_addr_i[CH_MSB:CH_LSB];
    assign rd_off   = rd_addr_i[OFF_MSB:0];
    assign rd_hi_ok = (rd_addr_i[31:CH_MSB+1] == '0);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic sel;
        assign sel = wr_en_i && wr_hi_ok && (wr_ch == 3'(g));

        timer_chan #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .ctrl_we_i   (sel && (wr_off == REG_CTRL)),
            .evalue_we_i (sel && (wr_off == REG_EVALUE)),
            .presc_we_i  (sel && (wr_off == REG_PRESC)),
            .wr_data_i   (wr_data_i),
            .ctrl_o      (ctrl_w[g]),
            .count_o     (count_w[g]),
            .evalue_o    (evalue_w[g]),
            .presc_o     (presc_w[g])
        );

        assign timer_int_vec_o[g] = ctrl_w[g].pend & ctrl_w[g].ie;
    end

    assign timer_int_flag_o = |timer_int_vec_o;

    // Read mux; channels >= NUM_CH never match and read as zero.
    always_comb begin
        rd_data_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rd_hi_ok && (rd_ch == 3'(i))) begin
                case (rd_off)
                    REG_CTRL:   rd_data_d = 32'(ctrl_w[i]);
                    REG_COUNT:  rd_data_d = 32'(count_w[i]);
                    REG_EVALUE: rd_data_d = 32'(evalue_w[i]);
                    REG_PRESC:  rd_data_d = 32'(presc_w[i]);
                    default:    rd_data_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_timer_multi.sv
// Directed self-checking bench for timer_multi: register-access vector table plus timing sequences.
module tb_timer_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en_i;
    logic [31:0] wr_addr_i;
    logic [31:0] wr_data_i;
    logic [31:0] rd_addr_i;
    logic [31:0] rd_data_o;
    logic [3:0]  timer_int_vec_o;
    logic        timer_int_flag_o;

    int n_checks = 0;
    int n_fail   = 0;

    timer_multi #(
        .NUM_CH  (4),
        .CNT_W   (32),
        .PRESC_W (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_en_i          (wr_en_i),
        .wr_addr_i        (wr_addr_i),
        .wr_data_i        (wr_data_i),
        .rd_addr_i        (rd_addr_i),
        .rd_data_o        (rd_data_o),
        .timer_int_vec_o  (timer_int_vec_o),
        .timer_int_flag_o (timer_int_flag_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr_en;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic [31:0] rd_addr;
        logic [31:0] exp_rd;
        logic [3:0]  exp_vec;
    } vec_t;

    localparam int NVEC = 20;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        @(negedge clk);
        wr_en_i   = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 32'h00, 32'h0,        32'h00, 32'h0,        4'h0};
        tbl[1]  = '{1'b1, 32'h08, 32'h12345678, 32'h08, 32'h0,        4'h0};
        tbl[2]  = '{1'b0, 32'h00, 32'h0,        32'h08, 32'h12345678, 4'h0};
        tbl[3]  = '{1'b1, 32'h0C, 32'hABCD1234, 32'h0C, 32'h0,        4'h0};
        tbl[4]  = '{1'b0, 32'h00, 32'h0,        32'h0C, 32'h1234,     4'h0};
        tbl[5]  = '{1'b1, 32'h04, 32'h55,       32'h04, 32'h0,        4'h0};
        tbl[6]  = '{1'b0, 32'h00, 32'h0,        32'h04, 32'h0,        4'h0};
        tbl[7]  = '{1'b1, 32'h58, 32'h77,       32'h58, 32'h0,        4'h0};
        tbl[8]  = '{1'b0, 32'h00, 32'h0,        32'h50, 32'h0,        4'h0};
        tbl[9]  = '{1'b1, 32'h00, 32'hFFFFFFF2, 32'h00, 32'h0,        4'h0};
        tbl[10] = '{1'b0, 32'h00, 32'h0,        32'h00, 32'h2,        4'h0};
        tbl[11] = '{1'b1, 32'h00, 32'h4,        32'h00, 32'h2,        4'h0};
        tbl[12] = '{1'b0, 32'h00, 32'h0,        32'h00, 32'h0,        4'h0};
        tbl[13] = '{1'b1, 32'h28, 32'h9,        32'h28, 32'h0,        4'h0};
        tbl[14] = '{1'b0, 32'h00, 32'h0,        32'h28, 32'h9,        4'h0};
        tbl[15] = '{1'b1, 32'h03, 32'hFF,       32'h18, 32'h0,        4'h0};
        tbl[16] = '{1'b0, 32'h00, 32'h0,        32'h03, 32'h0,        4'h0};
        tbl[17] = '{1'b1, 32'h1C, 32'h1FFFF,    32'h1C, 32'h0,        4'h0};
        tbl[18] = '{1'b0, 32'h00, 32'h0,        32'h1C, 32'hFFFF,     4'h0};
        tbl[19] = '{1'b1, 32'h1C, 32'h0,        32'h1C, 32'hFFFF,     4'h0};

        rst_n     = 1'b0;
        wr_en_i   = 1'b0;
        wr_addr_i = '0;
        wr_data_i = '0;
        rd_addr_i = '0;
        #1;
        check("reset_rd_data", rd_data_o, 32'h0);
        check("reset_vec", 32'(timer_int_vec_o), 32'h0);
        check("reset_flag", 32'(timer_int_flag_o), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Register access table: one cycle per row, read data is the pre-edge value.
        for (int i = 0; i < NVEC; i++) begin
            wr_en_i   = tbl[i].wr_en;
            wr_addr_i = tbl[i].wr_addr;
            wr_data_i = tbl[i].wr_data;
            rd_addr_i = tbl[i].rd_addr;
            @(negedge clk);
            check($sformatf("tbl%0d_rd", i), rd_data_o, tbl[i].exp_rd);
            check($sformatf("tbl%0d_vec", i), 32'(timer_int_vec_o), 32'(tbl[i].exp_vec));
        end
        wr_en_i = 1'b0;

        // One-shot expiry on ch0: EVALUE=5, PRESC=0, expires on 6th tick.
        wr(32'h08, 32'd5);
        wr(32'h0C, 32'd0);
        wr(32'h00, 32'h3);
        rd_addr_i = 32'h04;
        repeat (5) @(negedge clk);
        check("oneshot_count4", rd_data_o, 32'd4);
        check("oneshot_vec_pre", 32'(timer_int_vec_o), 32'h0);
        @(negedge clk);
        check("oneshot_count5", rd_data_o, 32'd5);
        check("oneshot_vec", 32'(timer_int_vec_o), 32'h1);
        check("oneshot_flag", 32'(timer_int_flag_o), 32'h1);
        @(negedge clk);
        check("oneshot_count0", rd_data_o, 32'd0);
        rd_addr_i = 32'h00;
        @(negedge clk);
        check("oneshot_ctrl", rd_data_o, 32'h6);

        // Pending clear: interrupt drops the cycle after the write.
        check("clr_vec_before", 32'(timer_int_vec_o), 32'h1);
        wr(32'h00, 32'h2);
        check("clr_vec_after", 32'(timer_int_vec_o), 32'h0);
        check("clr_flag_after", 32'(timer_int_flag_o), 32'h0);
        @(negedge clk);
        check("clr_ctrl", rd_data_o, 32'h2);

        // Periodic ch1: EVALUE=3, PRESC=2 -> expiry every 12 cycles.
        wr(32'h18, 32'd3);
        wr(32'h1C, 32'd2);
        wr(32'h10, 32'hB);
        repeat (11) @(negedge clk);
        check("per_vec_11", 32'(timer_int_vec_o), 32'h0);
        @(negedge clk);
        check("per_vec_12", 32'(timer_int_vec_o), 32'h2);
        wr(32'h10, 32'hB);
        check("per_vec_clr", 32'(timer_int_vec_o), 32'h0);
        repeat (10) @(negedge clk);
        check("per_vec_23", 32'(timer_int_vec_o), 32'h0);
        @(negedge clk);
        check("per_vec_24", 32'(timer_int_vec_o), 32'h2);
        rd_addr_i = 32'h10;
        @(negedge clk);
        check("per_ctrl", rd_data_o, 32'hF);
        wr(32'h10, 32'h0);

        // Pending-clear write in the expiry cycle: hardware wins, one-shot disables.
        wr(32'h08, 32'd2);
        wr(32'h00, 32'h3);
        repeat (2) @(negedge clk);
        check("race_vec_pre", 32'(timer_int_vec_o), 32'h0);
        wr(32'h00, 32'h3);
        check("race_vec", 32'(timer_int_vec_o), 32'h1);
        rd_addr_i = 32'h00;
        @(negedge clk);
        check("race_ctrl", rd_data_o, 32'h6);
        wr(32'h00, 32'h0);

        // ch0 and ch2 expire on the same edge.
        wr(32'h08, 32'd2);
        wr(32'h28, 32'd1);
        wr(32'h00, 32'h3);
        wr(32'h20, 32'h3);
        @(negedge clk);
        check("simul_vec_pre", 32'(timer_int_vec_o), 32'h0);
        @(negedge clk);
        check("simul_vec", 32'(timer_int_vec_o), 32'h5);
        check("simul_flag", 32'(timer_int_flag_o), 32'h1);
        wr(32'h00, 32'h0);
        wr(32'h20, 32'h0);

        // EVALUE lowered below the running count expires on the next tick.
        wr(32'h08, 32'd100);
        wr(32'h00, 32'h3);
        repeat (5) @(negedge clk);
        wr(32'h08, 32'd2);
        check("evlow_vec_pre", 32'(timer_int_vec_o), 32'h0);
        @(negedge clk);
        check("evlow_vec", 32'(timer_int_vec_o), 32'h1);
        wr(32'h00, 32'h0);

        // Reset asserted mid-count on ch3.
        wr(32'h38, 32'd1000);
        wr(32'h30, 32'h3);
        rd_addr_i = 32'h34;
        repeat (8) @(negedge clk);
        check("rst_pre_count", rd_data_o, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rd_data", rd_data_o, 32'h0);
        check("rst_vec", 32'(timer_int_vec_o), 32'h0);
        check("rst_flag", 32'(timer_int_flag_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_count_held", rd_data_o, 32'h0);
        rd_addr_i = 32'h30;
        @(negedge clk);
        check("rst_ctrl3", rd_data_o, 32'h0);
        rd_addr_i = 32'h38;
        @(negedge clk);
        check("rst_evalue3", rd_data_o, 32'h0);
        rd_addr_i = 32'h0C;
        @(negedge clk);
        check("rst_presc0", rd_data_o, 32'h0);
        rd_addr_i = 32'h34;
        @(negedge clk);
        check("rst_count_final", rd_data_o, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
